// File: rtl/video_out_hmag_core.sv
// Horizontal magnifier for the VDP video output.
// Each source line is captured into one of two line-buffer banks while the
// other bank (the previous line) is resampled at D/144 magnification.
// Build option: define VIDEO_OUT_HMAG_INTERP_EN for linear interpolation
// between neighbouring source pixels; without it the output is
// nearest-neighbour with identical phase stepping and latency.
module video_out_hmag_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [10:0] vdp_hcounter,
    input  logic [1:0]  vdp_vcounter,
    input  logic [5:0]  vdp_r,
    input  logic [5:0]  vdp_g,
    input  logic [5:0]  vdp_b,
    output logic [7:0]  video_r,
    output logic [7:0]  video_g,
    output logic [7:0]  video_b,
    input  logic [7:0]  reg_left_offset,
    input  logic [7:0]  reg_denominator,
    input  logic [5:0]  reg_normalize
);
    localparam logic [10:0] ACTIVE_END = 11'd1152;
    localparam logic [9:0]  SRC_LAST   = 10'd575;
    localparam logic [8:0]  PHASE_STEP = 9'd144;
    localparam logic [7:0]  DEN_MIN    = 8'd144;
    localparam logic [7:0]  DEN_MAX    = 8'd200;

    logic [17:0] bank0 [0:575];
    logic [17:0] bank1 [0:575];

    logic       line_start, tick_active;
    logic [7:0] den_clamped;
    logic [9:0] src_q, src_cur, src_next;
    logic [7:0] frac_q, frac_cur, frac_next;
    logic [7:0] den_q, den_cur;
    logic       line_ok_q, line_ok_cur;
    logic [8:0] phase_sum;
    logic       phase_step;

    assign line_start  = (vdp_hcounter == 11'd0);
    assign tick_active = enable && (vdp_hcounter < ACTIVE_END);

    // Current-tick phase: at line start the freshly sampled registers take effect immediately
    always_comb begin
        den_clamped = (reg_denominator < DEN_MIN) ? DEN_MIN :
                      (reg_denominator > DEN_MAX) ? DEN_MAX : reg_denominator;
        src_cur     = line_start ? {2'b00, reg_left_offset} : src_q;
        frac_cur    = line_start ? 8'd0 : frac_q;
        den_cur     = line_start ? den_clamped : den_q;
        line_ok_cur = line_start | line_ok_q;
        phase_sum   = {1'b0, frac_cur} + PHASE_STEP;
        phase_step  = (phase_sum >= {1'b0, den_cur});
        frac_next   = phase_step ? 8'(phase_sum - {1'b0, den_cur}) : phase_sum[7:0];
        src_next    = (phase_step && (src_cur != SRC_LAST)) ? src_cur + 10'd1 : src_cur;
    end

`ifdef VIDEO_OUT_HMAG_INTERP_EN
    logic [5:0] norm_q, norm_cur;
    logic [9:0] src_pair;
    assign norm_cur = line_start ? reg_normalize : norm_q;
    assign src_pair = (src_cur == SRC_LAST) ? SRC_LAST : src_cur + 10'd1;
`endif

    // Phase accumulator and per-line snapshot of the configuration inputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q     <= 10'd0;
            frac_q    <= 8'd0;
            den_q     <= DEN_MIN;
            line_ok_q <= 1'b0;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
            norm_q    <= 6'd0;
`endif
        end else begin
            if (line_start) begin
                den_q     <= den_clamped;
                line_ok_q <= 1'b1;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
                norm_q    <= reg_normalize;
`endif
            end
            if (tick_active) begin
                src_q  <= src_next;
                frac_q <= frac_next;
            end else if (line_start) begin
                src_q  <= src_cur;
                frac_q <= frac_cur;
            end
        end
    end

    // Capture the incoming line; memory contents survive reset
    always_ff @(posedge clk) begin
        if (tick_active) begin
            if (vdp_vcounter[0])
                bank1[vdp_hcounter[10:1]] <= {vdp_r, vdp_g, vdp_b};
            else
                bank0[vdp_hcounter[10:1]] <= {vdp_r, vdp_g, vdp_b};
        end
    end

    logic        p1, vis1;
    logic [17:0] a_q;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
    logic [17:0] b_q;
    logic [7:0]  den1, frac1;
    logic [5:0]  norm1;
`endif

    // Stage 1: registered read of the previous line's bank
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p1    <= 1'b0;
            vis1  <= 1'b0;
            a_q   <= 18'd0;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
            b_q   <= 18'd0;
            den1  <= 8'd0;
            frac1 <= 8'd0;
            norm1 <= 6'd0;
`endif
        end else begin
            p1 <= enable;
            if (enable) begin
                vis1 <= line_ok_cur && (vdp_hcounter < ACTIVE_END);
                a_q  <= vdp_vcounter[0] ? bank0[src_cur] : bank1[src_cur];
`ifdef VIDEO_OUT_HMAG_INTERP_EN
                b_q   <= vdp_vcounter[0] ? bank0[src_pair] : bank1[src_pair];
                den1  <= den_cur;
                frac1 <= frac_cur;
                norm1 <= norm_cur;
`endif
            end
        end
    end

    logic p2, vis2;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
    logic [19:0] prod_r_q, prod_g_q, prod_b_q;

    function automatic logic [19:0] lerp_scale(input logic [5:0] a, input logic [5:0] b,
                                               input logic [7:0] den, input logic [7:0] frac,
                                               input logic [5:0] norm);
        logic [7:0]  wa;
        logic [13:0] sum;
        wa  = den - frac;
        sum = ({8'd0, a} * {6'd0, wa}) + ({8'd0, b} * {6'd0, frac});
        return {6'd0, sum} * {14'd0, norm};
    endfunction

    function automatic logic [7:0] sat8(input logic [19:0] p);
        logic [19:0] s;
        s = p >> 11;
        return (s > 20'd255) ? 8'hFF : s[7:0];
    endfunction

    // Stage 2: weighted sum times the normalisation factor
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p2       <= 1'b0;
            vis2     <= 1'b0;
            prod_r_q <= 20'd0;
            prod_g_q <= 20'd0;
            prod_b_q <= 20'd0;
        end else begin
            p2 <= p1;
            if (p1) begin
                vis2     <= vis1;
                prod_r_q <= lerp_scale(a_q[17:12], b_q[17:12], den1, frac1, norm1);
                prod_g_q <= lerp_scale(a_q[11:6],  b_q[11:6],  den1, frac1, norm1);
                prod_b_q <= lerp_scale(a_q[5:0],   b_q[5:0],   den1, frac1, norm1);
            end
        end
    end

    // Stage 3: scale down, saturate, blank outside the visible window
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            video_r <= 8'd0;
            video_g <= 8'd0;
            video_b <= 8'd0;
        end else if (p2) begin
            video_r <= vis2 ? sat8(prod_r_q) : 8'd0;
            video_g <= vis2 ? sat8(prod_g_q) : 8'd0;
            video_b <= vis2 ? sat8(prod_b_q) : 8'd0;
        end
    end
`else
    logic [17:0] near_q;

    // Stage 2: carry the nearest source pixel so latency matches the interpolating build
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p2     <= 1'b0;
            vis2   <= 1'b0;
            near_q <= 18'd0;
        end else begin
            p2 <= p1;
            if (p1) begin
                vis2   <= vis1;
                near_q <= a_q;
            end
        end
    end

    // Stage 3: widen 6-bit colour to 8 bits by replicating the top bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            video_r <= 8'd0;
            video_g <= 8'd0;
            video_b <= 8'd0;
        end else if (p2) begin
            video_r <= vis2 ? {near_q[17:12], near_q[17:16]} : 8'd0;
            video_g <= vis2 ? {near_q[11:6],  near_q[11:10]} : 8'd0;
            video_b <= vis2 ? {near_q[5:0],   near_q[5:4]}   : 8'd0;
        end
    end
`endif

    logic unused_inputs;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
    assign unused_inputs = vdp_vcounter[1];
`else
    assign unused_inputs = ^{vdp_vcounter[1], reg_normalize};
`endif

endmodule

// File: tb/tb_video_out_hmag_core.sv
// Bench for video_out_hmag_core: drives whole video lines with directed
// pixel patterns and register settings, queues the expected output per
// pixel tick, and a monitor compares three clocks later.
module tb_video_out_hmag_core;
    logic        clk = 1'b0;
    logic        reset_n, enable;
    logic [10:0] vdp_hcounter;
    logic [1:0]  vdp_vcounter;
    logic [5:0]  vdp_r, vdp_g, vdp_b;
    logic [7:0]  video_r, video_g, video_b;
    logic [7:0]  reg_left_offset, reg_denominator;
    logic [5:0]  reg_normalize;

    always #5 clk = ~clk;

    video_out_hmag_core dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .vdp_hcounter    (vdp_hcounter),
        .vdp_vcounter    (vdp_vcounter),
        .vdp_r           (vdp_r),
        .vdp_g           (vdp_g),
        .vdp_b           (vdp_b),
        .video_r         (video_r),
        .video_g         (video_g),
        .video_b         (video_b),
        .reg_left_offset (reg_left_offset),
        .reg_denominator (reg_denominator),
        .reg_normalize   (reg_normalize)
    );

    typedef struct {
        logic [7:0] r, g, b;
        int         line, k;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int mr[2][576];
    int mg[2][576];
    int mb[2][576];
    int m_src = 0, m_frac = 0, m_den = 200, m_norm = 40;
    bit m_ok = 1'b0;

    // pattern 0: r=1; 1: all 63; 2: ramp; 3: pixel 0 black, rest 63
    task automatic pattern(input int pat, input int i, output int r, output int g, output int b);
        case (pat)
            0: begin r = 1; g = 0; b = 0; end
            1: begin r = 63; g = 63; b = 63; end
            2: begin r = i % 64; g = 63 - (i % 64); b = (3 * i) % 64; end
            default: begin r = (i == 0) ? 0 : 63; g = r; b = r; end
        endcase
    endtask

    function automatic int expect_chan(int a, int bnext, int den, int frac, int norm);
        int v;
`ifdef VIDEO_OUT_HMAG_INTERP_EN
        v = ((a * (den - frac) + bnext * frac) * norm) >> 11;
        if (v > 255) v = 255;
`else
        v = a * 4 + a / 16;
`endif
        return v;
    endfunction

    task automatic drive_line(input int line, input int pat, input int off, input int den,
                              input int norm, input int rst_from, input int rst_to,
                              input int den_alt_at);
        int   r, g, b, rb, s1, fsum;
        exp_t e;
        for (int h = 0; h < 1368; h++) begin
            @(posedge clk);
            #1;
            reset_n = (h >= rst_from && h < rst_to) ? 1'b0 : 1'b1;
            if (!reset_n) m_ok = 1'b0;
            vdp_hcounter = 11'(h);
            vdp_vcounter = 2'(line);
            enable       = (h % 2 == 0);
            if (h == 0) begin
                reg_left_offset = 8'(off);
                reg_denominator = 8'(den);
                reg_normalize   = 6'(norm);
            end
            if (h == den_alt_at) reg_denominator = 8'd144;
            if (enable) begin
                pattern(pat, h / 2, r, g, b);
                vdp_r = 6'(r);
                vdp_g = 6'(g);
                vdp_b = 6'(b);
                if (h == 0 && reset_n) begin
                    m_src  = off;
                    m_frac = 0;
                    m_den  = (den < 144) ? 144 : (den > 200) ? 200 : den;
                    m_norm = norm;
                    m_ok   = 1'b1;
                end
                e.line = line;
                e.k    = h / 2;
                e.r    = 8'd0;
                e.g    = 8'd0;
                e.b    = 8'd0;
                if (h < 1152) begin
                    if (m_ok) begin
                        rb  = (line % 2) ^ 1;
                        s1  = (m_src < 575) ? m_src + 1 : 575;
                        e.r = 8'(expect_chan(mr[rb][m_src], mr[rb][s1], m_den, m_frac, m_norm));
                        e.g = 8'(expect_chan(mg[rb][m_src], mg[rb][s1], m_den, m_frac, m_norm));
                        e.b = 8'(expect_chan(mb[rb][m_src], mb[rb][s1], m_den, m_frac, m_norm));
                    end
                    fsum = m_frac + 144;
                    if (fsum >= m_den) begin
                        m_frac = fsum - m_den;
                        if (m_src < 575) m_src++;
                    end else begin
                        m_frac = fsum;
                    end
                    mr[line % 2][h / 2] = r;
                    mg[line % 2][h / 2] = g;
                    mb[line % 2][h / 2] = b;
                end
                sbq.push_back(e);
            end
        end
    endtask

    logic [2:0] tick_hist = 3'b000;
    logic [2:0] rst_hist  = 3'b000;

    // Remember which edges carried a tick and whether reset was active
    always @(posedge clk) begin
        tick_hist <= {tick_hist[1:0], enable};
        rst_hist  <= {rst_hist[1:0], reset_n};
    end

    // Monitor: a tick's result is due after the third edge counting the tick edge
    always @(negedge clk) begin
        exp_t e;
        if (tick_hist[2]) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL pix_unexpected: got %0d/%0d/%0d, want no output", video_r, video_g, video_b);
            end else begin
                e = sbq.pop_front();
                if (rst_hist != 3'b111) begin
                    e.r = 8'd0;
                    e.g = 8'd0;
                    e.b = 8'd0;
                end
                if ({video_r, video_g, video_b} !== {e.r, e.g, e.b}) begin
                    n_fail++;
                    $display("FAIL pix line%0d k%0d: got r/g/b %0d/%0d/%0d, want %0d/%0d/%0d",
                             e.line, e.k, video_r, video_g, video_b, e.r, e.g, e.b);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        enable          = 1'b0;
        vdp_hcounter    = 11'd1300;
        vdp_vcounter    = 2'd0;
        vdp_r           = 6'd0;
        vdp_g           = 6'd0;
        vdp_b           = 6'd0;
        reg_left_offset = 8'd0;
        reg_denominator = 8'd200;
        reg_normalize   = 6'd40;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({video_r, video_g, video_b} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d/%0d/%0d, want 0/0/0", video_r, video_g, video_b);
        end

        // line, pattern, offset, denominator, normalize, reset window, denominator change
        drive_line(0, 0, 0,   200, 40, 0,   600, -1);
        drive_line(1, 1, 0,   200, 40, -1,  -1,  -1);
        drive_line(2, 2, 0,   200, 40, -1,  -1,  -1);
        drive_line(3, 2, 0,   144, 56, -1,  -1,  -1);
        drive_line(4, 1, 112, 144, 56, -1,  -1,  -1);
        drive_line(5, 3, 0,   144, 56, 400, 420, -1);
        drive_line(6, 2, 0,   200, 40, -1,  -1,  -1);
        drive_line(7, 2, 0,   200, 40, -1,  -1,  300);
        drive_line(8, 2, 5,   255, 40, -1,  -1,  -1);

        @(posedge clk);
        #1;
        enable       = 1'b0;
        vdp_hcounter = 11'd1300;
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, want 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
